// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive buffer.
//   rx_entry_t       one stored frame: break/framing/parity flags plus character
//   rx_trig_e        FCR[7:6] receive trigger selector
//   RX_DATA_W        character width carried by rx_entry_t
//   RX_TIMEOUT_CHARS idle character times before a receive timeout is flagged
//   trig_level()     trigger selector -> occupancy threshold for a given depth
package uart_rx_pkg;

  localparam int RX_DATA_W        = 8;
  localparam int RX_TIMEOUT_CHARS = 4;

  typedef struct packed {
    logic                 bi;
    logic                 fe;
    logic                 pe;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    TRIG_1   = 2'b00,
    TRIG_Q   = 2'b01,
    TRIG_H   = 2'b10,
    TRIG_FM2 = 2'b11
  } rx_trig_e;

  function automatic int unsigned trig_level(rx_trig_e sel, int unsigned depth);
    case (sel)
      TRIG_1:  return 1;
      TRIG_Q:  return depth / 4;
      TRIG_H:  return depth / 2;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundle between the receiver / APB register block and the
// receive buffer.
//   master modport: drives FCR controls, push frame, pop/LSR read strobes,
//                   char_tick; observes RBR head and LSR/IIR status.
//   slave modport:  the receive buffer (uart_rx_fifo).
// Parameters DEPTH / DATA_W must match those of the attached uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = uart_rx_pkg::RX_DATA_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Controls and push side
  logic              fifo_en;
  logic              rx_fifo_clear;
  logic [1:0]        rx_trig;
  logic              receive_load_en;
  logic [DATA_W-1:0] rsr_data;
  logic              parity_error;
  logic              frame_error;
  logic              uart_break;
  logic              rbr_read;
  logic              lsr_read;
  logic              char_tick;
  // Head entry and status
  logic [DATA_W-1:0] rbr_data;
  logic              head_pe;
  logic              head_fe;
  logic              head_bi;
  logic              data_ready;
  logic              overrun_error;
  logic              rx_fifo_error;
  logic              rx_trigger;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_timeout;

  modport master (
    output fifo_en, rx_fifo_clear, rx_trig, receive_load_en, rsr_data,
           parity_error, frame_error, uart_break, rbr_read, lsr_read, char_tick,
    input  rbr_data, head_pe, head_fe, head_bi, data_ready, overrun_error,
           rx_fifo_error, rx_trigger, rx_count, rx_timeout
  );

  modport slave (
    input  fifo_en, rx_fifo_clear, rx_trig, receive_load_en, rsr_data,
           parity_error, frame_error, uart_break, rbr_read, lsr_read, char_tick,
    output rbr_data, head_pe, head_fe, head_bi, data_ready, overrun_error,
           rx_fifo_error, rx_trigger, rx_count, rx_timeout
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic single-clock FIFO of rx_entry_t with show-ahead read.
//   clk, rst_n  clock, synchronous active-low reset
//   push/wdata  write strobe and entry; ignored when full unless popping too
//   pop         read strobe; ignored when empty
//   flush       empties the FIFO; wins over push and pop
//   rdata       entry at the read pointer (undefined contents while empty)
//   count       occupancy, one bit wider than the pointers
//   full/empty  occupancy flags
module uart_sync_fifo
  import uart_rx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  rx_entry_t        wdata,
  output rx_entry_t        rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rx_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an empty FIFO's contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style receive buffer between uart_receiver_top and the
// APB register block.
//   pclk, presetn  clock, synchronous active-low reset
//   bus            uart_rx_fifo_if.slave: FCR controls, push frame, RBR/LSR
//                  read strobes, char_tick in; RBR head, DR, OE, LSR[7],
//                  trigger, count and timeout out.
// Optional feature: define UART_RX_TIMEOUT_EN to build the character timeout;
// otherwise rx_timeout is tied 0 and char_tick is unused.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = RX_DATA_W,  // storage width comes from rx_entry_t
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic           pclk,
  input  logic           presetn,
  uart_rx_fifo_if.slave  bus
);

  rx_entry_t        wentry, head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             fifo_en_q;
  logic             oe_q, oe_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             flush, pop_ok, at_cap, overrun, overwrite;
  logic             fifo_push, fifo_pop;

  assign wentry = '{bi: bus.uart_break, fe: bus.frame_error,
                    pe: bus.parity_error, data: bus.rsr_data};

  // Any change of FIFO mode discards the stored frames, like an FCR clear.
  assign flush  = bus.rx_fifo_clear || (bus.fifo_en != fifo_en_q);
  assign pop_ok = bus.rbr_read && !empty;
  // Holding-register mode has a capacity of one entry.
  assign at_cap = bus.fifo_en ? full : !empty;

  always_comb begin
    overrun   = bus.receive_load_en && !flush && !pop_ok && at_cap;
    // Holding register: the newer frame replaces the unread one.
    overwrite = overrun && !bus.fifo_en;
    fifo_push = bus.receive_load_en && !flush && !(overrun && bus.fifo_en);
    fifo_pop  = pop_ok || overwrite;
  end

  uart_sync_fifo #(.DEPTH(DEPTH)) u_store (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Counts stored entries carrying PE/FE/BI, so LSR[7] needs no scan of the array.
  always_comb begin
    err_cnt_d = err_cnt_q;
    oe_d      = oe_q;
    if (flush) begin
      err_cnt_d = '0;
    end else begin
      err_cnt_d = err_cnt_q
                + CNT_W'(fifo_push && (wentry.pe || wentry.fe || wentry.bi))
                - CNT_W'(fifo_pop  && (head.pe   || head.fe   || head.bi));
    end
    // A fresh overrun beats the LSR read that would otherwise clear OE.
    if (overrun)           oe_d = 1'b1;
    else if (bus.lsr_read) oe_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      // Track the live mode through reset so leaving reset is not seen as a mode toggle.
      fifo_en_q <= bus.fifo_en;
      oe_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      fifo_en_q <= bus.fifo_en;
      oe_q      <= oe_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Head is forced to zero while empty so unwritten storage is never exposed.
  assign bus.rbr_data      = empty ? '0   : head.data;
  assign bus.head_pe       = !empty && head.pe;
  assign bus.head_fe       = !empty && head.fe;
  assign bus.head_bi       = !empty && head.bi;
  assign bus.data_ready    = !empty;
  assign bus.overrun_error = oe_q;
  assign bus.rx_fifo_error = (err_cnt_q != '0);
  assign bus.rx_count      = count;
  assign bus.rx_trigger    = (count >= CNT_W'(trig_level(rx_trig_e'(bus.rx_trig), DEPTH)));

`ifdef UART_RX_TIMEOUT_EN
  logic [2:0] idle_q, idle_d;
  logic       activity;

  always_comb begin
    activity = bus.receive_load_en || bus.rbr_read || flush;
    idle_d   = idle_q;
    if (activity) begin
      idle_d = '0;
    end else if (bus.char_tick && !empty && bus.fifo_en &&
                 (idle_q != 3'(RX_TIMEOUT_CHARS))) begin
      // Saturates at the threshold so the timeout holds until the next activity.
      idle_d = idle_q + 3'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) idle_q <= '0;
    else          idle_q <= idle_d;
  end

  assign bus.rx_timeout = (idle_q == 3'(RX_TIMEOUT_CHARS));
`else
  assign bus.rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo. Directed scenarios plus
// a randomized run against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       pe, fe, bi;
  } ent_t;

  logic pclk = 1'b0;
  logic presetn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 pclk = ~pclk;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.slave)
  );

  // ---------------- reference model ----------------
  ent_t mq[$];
  bit   m_oe;
  bit   m_en_prev;
  int   m_idle;

  task automatic model_update();
    bit   flush, ovr, act;
    int   cap;
    ent_t e;
    if (!presetn) begin
      mq.delete();
      m_oe      = 1'b0;
      m_idle    = 0;
      m_en_prev = bus.fifo_en;
      return;
    end
    e.data = bus.rsr_data; e.pe = bus.parity_error;
    e.fe   = bus.frame_error; e.bi = bus.uart_break;
    flush = bus.rx_fifo_clear || (bus.fifo_en != m_en_prev);
    m_en_prev = bus.fifo_en;
    act = bus.receive_load_en || bus.rbr_read || flush;
    ovr = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (bus.rbr_read && mq.size() > 0) void'(mq.pop_front());
      if (bus.receive_load_en) begin
        cap = bus.fifo_en ? DEPTH : 1;
        if (mq.size() < cap) mq.push_back(e);
        else begin
          ovr = 1'b1;
          if (!bus.fifo_en) mq[0] = e;
        end
      end
    end
    if (ovr) m_oe = 1'b1;
    else if (bus.lsr_read) m_oe = 1'b0;
    if (act) m_idle = 0;
    else if (bus.char_tick && mq.size() > 0 && bus.fifo_en && m_idle < 4) m_idle++;
  endtask

  function automatic bit exp_err();
    foreach (mq[i]) if (mq[i].pe || mq[i].fe || mq[i].bi) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_trig();
    int lvl;
    case (bus.rx_trig)
      2'b00:   lvl = 1;
      2'b01:   lvl = DEPTH / 4;
      2'b10:   lvl = DEPTH / 2;
      default: lvl = DEPTH - 2;
    endcase
    return mq.size() >= lvl;
  endfunction

  function automatic logic [7:0] exp_data();
    return (mq.size() > 0) ? mq[0].data : 8'h00;
  endfunction

  function automatic bit exp_to();
    return TO_EN && (m_idle >= 4);
  endfunction

  // One clock: DUT and model see the same inputs; strobes drop afterwards.
  task automatic step();
    @(posedge pclk);
    model_update();
    #1;
    bus.receive_load_en = 1'b0;
    bus.rbr_read        = 1'b0;
    bus.lsr_read        = 1'b0;
    bus.rx_fifo_clear   = 1'b0;
    bus.char_tick       = 1'b0;
    bus.parity_error    = 1'b0;
    bus.frame_error     = 1'b0;
    bus.uart_break      = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit pe = 1'b0);
    bus.receive_load_en = 1'b1;
    bus.rsr_data        = d;
    bus.parity_error    = pe;
    step();
  endtask

  task automatic pop();
    bus.rbr_read = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    presetn = 1'b0;
    step(); step();
    n_checks++; if (bus.rx_count !== 5'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", bus.rx_count); end
    n_checks++; if (bus.data_ready !== 1'b0) begin n_errors++; $display("FAIL reset_dr got %b exp 0", bus.data_ready); end
    n_checks++; if (bus.overrun_error !== 1'b0) begin n_errors++; $display("FAIL reset_oe got %b exp 0", bus.overrun_error); end
    n_checks++; if (bus.rx_fifo_error !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", bus.rx_fifo_error); end
    n_checks++; if (bus.rbr_data !== 8'h00) begin n_errors++; $display("FAIL reset_rbr got %h exp 00", bus.rbr_data); end
    n_checks++; if (bus.rx_trigger !== 1'b0) begin n_errors++; $display("FAIL reset_trig got %b exp 0", bus.rx_trigger); end
    n_checks++; if (bus.rx_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_to got %b exp 0", bus.rx_timeout); end
    presetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    push(8'hA5);
    n_checks++; if (bus.data_ready !== 1'b1) begin n_errors++; $display("FAIL single_dr got %b exp 1", bus.data_ready); end
    n_checks++; if (bus.rbr_data !== 8'hA5) begin n_errors++; $display("FAIL single_rbr got %h exp a5", bus.rbr_data); end
    n_checks++; if (bus.rx_count !== 5'd1) begin n_errors++; $display("FAIL single_count got %0d exp 1", bus.rx_count); end
    pop();
    n_checks++; if (bus.data_ready !== 1'b0) begin n_errors++; $display("FAIL single_pop_dr got %b exp 0", bus.data_ready); end
    pop();  // pop when empty is ignored
    n_checks++; if (bus.rx_count !== 5'd0 || bus.rbr_data !== 8'h00) begin n_errors++; $display("FAIL empty_pop got cnt %0d rbr %h exp 0 00", bus.rx_count, bus.rbr_data); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i <= 16; i++) push(8'(i));
    n_checks++; if (bus.rx_count !== 5'd16) begin n_errors++; $display("FAIL ovr_count got %0d exp 16", bus.rx_count); end
    n_checks++; if (bus.overrun_error !== 1'b1) begin n_errors++; $display("FAIL ovr_oe got %b exp 1", bus.overrun_error); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.rbr_data !== 8'(i)) begin n_errors++; $display("FAIL ovr_order[%0d] got %h exp %h", i, bus.rbr_data, 8'(i)); end
      pop();
    end
    n_checks++; if (bus.data_ready !== 1'b0) begin n_errors++; $display("FAIL ovr_drained got %b exp 0", bus.data_ready); end
    n_checks++; if (bus.overrun_error !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun_error); end
    bus.lsr_read = 1'b1;
    step();
    n_checks++; if (bus.overrun_error !== 1'b0) begin n_errors++; $display("FAIL ovr_lsr_clear got %b exp 0", bus.overrun_error); end
  endtask

  task automatic test_error_flags();
    push(8'h11, 1'b1);
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
    n_checks++; if (bus.rx_fifo_error !== 1'b1) begin n_errors++; $display("FAIL err_set got %b exp 1", bus.rx_fifo_error); end
    n_checks++; if (bus.head_pe !== 1'b1) begin n_errors++; $display("FAIL err_head_pe got %b exp 1", bus.head_pe); end
    pop();
    n_checks++; if (bus.rx_fifo_error !== 1'b0) begin n_errors++; $display("FAIL err_clear got %b exp 0", bus.rx_fifo_error); end
    n_checks++; if (bus.head_pe !== 1'b0 || bus.rbr_data !== 8'h20) begin n_errors++; $display("FAIL err_next_head got pe %b rbr %h exp 0 20", bus.head_pe, bus.rbr_data); end
    for (int i = 0; i < 3; i++) pop();
  endtask

  task automatic test_trigger();
    bus.rx_trig = 2'b10;
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    n_checks++; if (bus.rx_trigger !== 1'b0) begin n_errors++; $display("FAIL trig_7 got %b exp 0", bus.rx_trigger); end
    push(8'h47);
    n_checks++; if (bus.rx_trigger !== 1'b1) begin n_errors++; $display("FAIL trig_8 got %b exp 1", bus.rx_trigger); end
    for (int i = 8; i < 16; i++) push(8'h40 + 8'(i));
    bus.receive_load_en = 1'b1;
    bus.rsr_data        = 8'h99;
    bus.rbr_read        = 1'b1;
    step();
    n_checks++; if (bus.rx_count !== 5'd16) begin n_errors++; $display("FAIL full_pushpop_count got %0d exp 16", bus.rx_count); end
    n_checks++; if (bus.overrun_error !== 1'b0) begin n_errors++; $display("FAIL full_pushpop_oe got %b exp 0", bus.overrun_error); end
    n_checks++; if (bus.rbr_data !== 8'h41) begin n_errors++; $display("FAIL full_pushpop_head got %h exp 41", bus.rbr_data); end
    bus.rx_fifo_clear = 1'b1;
    step();
    n_checks++; if (bus.rx_count !== 5'd0 || bus.rx_trigger !== 1'b0) begin n_errors++; $display("FAIL clear got cnt %0d trig %b exp 0 0", bus.rx_count, bus.rx_trigger); end
    bus.rx_trig = 2'b00;
  endtask

  task automatic test_nonfifo();
    bus.fifo_en = 1'b0;
    step();
    push(8'h33);
    push(8'h44);
    n_checks++; if (bus.rbr_data !== 8'h44) begin n_errors++; $display("FAIL hold_rbr got %h exp 44", bus.rbr_data); end
    n_checks++; if (bus.overrun_error !== 1'b1) begin n_errors++; $display("FAIL hold_oe got %b exp 1", bus.overrun_error); end
    n_checks++; if (bus.rx_count !== 5'd1) begin n_errors++; $display("FAIL hold_count got %0d exp 1", bus.rx_count); end
    bus.lsr_read = 1'b1;  // read coincides with a fresh overrun
    push(8'h55);
    n_checks++; if (bus.overrun_error !== 1'b1 || bus.rbr_data !== 8'h55) begin n_errors++; $display("FAIL hold_lsr_ovr got oe %b rbr %h exp 1 55", bus.overrun_error, bus.rbr_data); end
    bus.lsr_read = 1'b1;
    step();
    n_checks++; if (bus.overrun_error !== 1'b0) begin n_errors++; $display("FAIL hold_lsr got %b exp 0", bus.overrun_error); end
    bus.rbr_read = 1'b1;
    push(8'h66);
    n_checks++; if (bus.overrun_error !== 1'b0 || bus.rbr_data !== 8'h66) begin n_errors++; $display("FAIL hold_pushpop got oe %b rbr %h exp 0 66", bus.overrun_error, bus.rbr_data); end
    bus.rx_fifo_clear = 1'b1;
    push(8'h77);
    n_checks++; if (bus.rx_count !== 5'd0 || bus.data_ready !== 1'b0) begin n_errors++; $display("FAIL clear_push got cnt %0d dr %b exp 0 0", bus.rx_count, bus.data_ready); end
    bus.fifo_en = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    push(8'h5A);
    for (int i = 1; i <= 6; i++) begin
      bus.char_tick = 1'b1;
      step();
      n_checks++; if (bus.rx_timeout !== (TO_EN && i >= 4)) begin n_errors++; $display("FAIL timeout_tick%0d got %b exp %b", i, bus.rx_timeout, TO_EN && i >= 4); end
    end
    pop();
    n_checks++; if (bus.rx_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_pop got %b exp 0", bus.rx_timeout); end
  endtask

  task automatic test_random();
    int pw, rw;
    for (int c = 0; c < 600; c++) begin
      // Alternate fill-heavy and drain-heavy phases so full and empty are both reached.
      pw = ((c / 100) % 2 == 0) ? 75 : 30;
      rw = ((c / 100) % 2 == 0) ? 20 : 60;
      bus.receive_load_en = ($urandom_range(0, 99) < pw);
      bus.rsr_data        = 8'($urandom);
      bus.parity_error    = ($urandom_range(0, 9) == 0);
      bus.frame_error     = ($urandom_range(0, 19) == 0);
      bus.uart_break      = ($urandom_range(0, 29) == 0);
      bus.rbr_read        = ($urandom_range(0, 99) < rw);
      bus.lsr_read        = ($urandom_range(0, 99) < 8);
      bus.rx_fifo_clear   = ($urandom_range(0, 199) == 0);
      bus.char_tick       = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 149) == 0) bus.fifo_en = ~bus.fifo_en;
      if ($urandom_range(0, 49) == 0)  bus.rx_trig = 2'($urandom);
      step();
      n_checks++; if (bus.rx_count !== 5'(mq.size())) begin n_errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.rx_count, mq.size()); end
      n_checks++; if (bus.rbr_data !== exp_data()) begin n_errors++; $display("FAIL rnd_rbr c%0d got %h exp %h", c, bus.rbr_data, exp_data()); end
      n_checks++; if (bus.overrun_error !== m_oe) begin n_errors++; $display("FAIL rnd_oe c%0d got %b exp %b", c, bus.overrun_error, m_oe); end
      n_checks++; if (bus.rx_fifo_error !== exp_err()) begin n_errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, bus.rx_fifo_error, exp_err()); end
      n_checks++; if (bus.rx_trigger !== exp_trig()) begin n_errors++; $display("FAIL rnd_trig c%0d got %b exp %b", c, bus.rx_trigger, exp_trig()); end
      n_checks++; if (bus.rx_timeout !== exp_to()) begin n_errors++; $display("FAIL rnd_to c%0d got %b exp %b", c, bus.rx_timeout, exp_to()); end
      n_checks++; if (mq.size() > 0 && {bus.head_bi, bus.head_fe, bus.head_pe} !== {mq[0].bi, mq[0].fe, mq[0].pe}) begin n_errors++; $display("FAIL rnd_head_flags c%0d got %b%b%b exp %b%b%b", c, bus.head_bi, bus.head_fe, bus.head_pe, mq[0].bi, mq[0].fe, mq[0].pe); end
    end
  endtask

  task automatic test_reset_midstream();
    bus.fifo_en = 1'b1;
    step();
    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i), i == 2);
    presetn = 1'b0;
    step();
    n_checks++; if (bus.rx_count !== 5'd0 || bus.data_ready !== 1'b0) begin n_errors++; $display("FAIL mid_reset_count got %0d dr %b exp 0 0", bus.rx_count, bus.data_ready); end
    n_checks++; if (bus.overrun_error !== 1'b0 || bus.rx_fifo_error !== 1'b0) begin n_errors++; $display("FAIL mid_reset_flags got oe %b err %b exp 0 0", bus.overrun_error, bus.rx_fifo_error); end
    n_checks++; if (bus.rbr_data !== 8'h00 || bus.rx_timeout !== 1'b0) begin n_errors++; $display("FAIL mid_reset_out got rbr %h to %b exp 00 0", bus.rbr_data, bus.rx_timeout); end
    presetn = 1'b1;
    step();
  endtask

  initial begin
    presetn             = 1'b0;
    bus.fifo_en         = 1'b1;
    bus.rx_fifo_clear   = 1'b0;
    bus.rx_trig         = 2'b00;
    bus.receive_load_en = 1'b0;
    bus.rsr_data        = 8'h00;
    bus.parity_error    = 1'b0;
    bus.frame_error     = 1'b0;
    bus.uart_break      = 1'b0;
    bus.rbr_read        = 1'b0;
    bus.lsr_read        = 1'b0;
    bus.char_tick       = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_error_flags();
    test_trigger();
    test_nonfifo();
    test_timeout();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

endmodule
